// File: rtl/mm_bridge.sv
// mm_bridge: single-outstanding Avalon-MM bridge with registered replay, fixed read latency and downstream timeout
module mm_bridge #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic [3:0]  s_byteenable,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic        s_readdatavalid,
  output logic [31:0] m_address,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  output logic        m_read,
  output logic        m_write,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic [7:0]  timeouts
);
  typedef enum logic [1:0] {IDLE, CMD, WAIT_RD, RESP} state_t;
  state_t state, next;
  logic is_wr, accept, done, abort, busy;
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    busy = state == CMD || state == WAIT_RD;
    accept = state == IDLE && (s_read || s_write);
    done = state == CMD ? !m_waitrequest : state == WAIT_RD && m_readdatavalid;
    abort = busy && !done && cnt == 8'(TIMEOUT - 1);
    next = state;
    case (state)
      IDLE:    next = accept ? CMD : IDLE;
      CMD:     next = done ? (is_wr ? IDLE : m_readdatavalid ? RESP : WAIT_RD)
                    : abort ? (is_wr ? IDLE : RESP) : CMD;
      WAIT_RD: next = done || abort ? RESP : WAIT_RD;
      default: next = IDLE;
    endcase
  end
  always_comb s_waitrequest = !rst || state != IDLE;
  // Strobes and response are computed from next state so every master-side output is registered.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      m_address       <= '0;
      m_writedata     <= '0;
      m_byteenable    <= '0;
      m_read          <= 1'b0;
      m_write         <= 1'b0;
      is_wr           <= 1'b0;
      cnt             <= '0;
      s_readdata      <= '0;
      s_readdatavalid <= 1'b0;
      timeouts        <= '0;
    end else begin
      if (accept) begin
        m_address    <= s_address;
        m_writedata  <= s_writedata;
        m_byteenable <= s_byteenable;
        is_wr        <= s_write;
      end
      m_read          <= next == CMD && !(accept ? s_write : is_wr);
      m_write         <= next == CMD && (accept ? s_write : is_wr);
      cnt             <= busy ? cnt + 8'd1 : '0;
      s_readdatavalid <= next == RESP;
      if (next == RESP) s_readdata <= abort ? ERR_DATA : m_readdata;
      if (abort && timeouts != 8'hFF) timeouts <= timeouts + 8'd1;
    end
endmodule

// File: tb/tb_mm_bridge.sv
// tb_mm_bridge: directed and randomized checks of mm_bridge against a register-bank slave and a memory/latency model
module tb_mm_bridge;
  localparam int TO = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] s_address = '0, s_writedata = '0;
  logic s_read = 1'b0, s_write = 1'b0;
  logic [3:0] s_byteenable = '0;
  logic s_waitrequest, s_readdatavalid;
  logic [31:0] s_readdata, m_address, m_writedata, m_readdata;
  logic [3:0] m_byteenable;
  logic m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [7:0] timeouts;
  int checks = 0, errors = 0, cyc = 0, nreads = 0;
  int wait_n = 0, rdv_d = 0, wcnt = 0, dcnt = 0;
  bit never = 0, pend = 0;
  int rdv_pulses = 0, mread_cyc = 0;
  logic [31:0] mem [8] = '{default: 32'h0};
  logic [31:0] ref_mem [8] = '{default: 32'h0};

  mm_bridge #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid), .timeouts(timeouts)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: holds waitrequest for wait_n cycles, returns readdatavalid rdv_d cycles after acceptance
  assign m_waitrequest   = (m_read || m_write) && wcnt < wait_n;
  assign m_readdatavalid = !never && ((m_read && !m_waitrequest && rdv_d == 0) || (pend && dcnt == rdv_d));
  assign m_readdata      = mem[m_address[4:2]];
  always @(posedge clk) begin
    wcnt <= (m_read || m_write) && m_waitrequest ? wcnt + 1 : 0;
    if (m_write && !m_waitrequest)
      for (int i = 0; i < 4; i++)
        if (m_byteenable[i]) mem[m_address[4:2]][8*i +: 8] <= m_writedata[8*i +: 8];
    if (pend) begin
      if (dcnt == rdv_d) pend <= 0;
      else dcnt <= dcnt + 1;
    end else if (m_read && !m_waitrequest && rdv_d != 0 && !never) begin
      pend <= 1;
      dcnt <= 1;
    end
  end

  always @(negedge clk) begin
    if (s_readdatavalid) rdv_pulses <= rdv_pulses + 1;
    if (m_read) mread_cyc <= mread_cyc + 1;
  end

  function automatic logic [31:0] merge(input logic [31:0] old, d, input logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, wr, input logic [31:0] a, d, input logic [3:0] be, output int acc);
    int n = 0;
    @(negedge clk);
    s_read = rd; s_write = wr; s_address = a; s_writedata = d; s_byteenable = be;
    while (s_waitrequest && n < 200) begin @(negedge clk); n++; end
    chk("accept_bound", 32'(n < 200), 32'd1);
    acc = cyc;
    if (wr) ref_mem[a[4:2]] = merge(ref_mem[a[4:2]], d, be);
    @(posedge clk);
    #1 s_read = 0; s_write = 0;
  endtask

  task automatic get_rd(input string tag, input int acc, input logic [31:0] expd, input int lat);
    int n = 0;
    bit stall_ok = 1;
    do begin
      @(negedge clk);
      n++;
      if (!s_readdatavalid && !s_waitrequest) stall_ok = 0;
    end while (!s_readdatavalid && n < 400);
    nreads++;
    chk({tag, "_rdv"}, 32'(s_readdatavalid), 32'd1);
    chk({tag, "_lat"}, 32'(cyc - acc), 32'(lat));
    chk({tag, "_data"}, s_readdata, expd);
    chk({tag, "_stall"}, 32'(stall_ok && s_waitrequest), 32'd1);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(s_readdatavalid), 32'd0);
    chk({tag, "_idle"}, 32'(s_waitrequest), 32'd0);
  endtask

  initial begin
    int a1, a2, p0, m0;
    logic [31:0] d, a;
    logic [3:0] be;
    repeat (3) @(negedge clk);
    chk("rst_wait", 32'(s_waitrequest), 32'd1);
    chk("rst_mrd", 32'({m_read, m_write}), 32'd0);
    chk("rst_maddr", m_address, 32'd0);
    chk("rst_mwd", m_writedata, 32'd0);
    chk("rst_mbe", 32'(m_byteenable), 32'd0);
    chk("rst_srd", s_readdata, 32'd0);
    chk("rst_srdv", 32'(s_readdatavalid), 32'd0);
    chk("rst_tmo", 32'(timeouts), 32'd0);
    rst = 1;
    @(negedge clk);
    chk("idle_wait", 32'(s_waitrequest), 32'd0);
    // Zero-wait register bank: write then read address 8
    issue(0, 1, 32'd8, 32'h12345678, 4'hF, a1);
    issue(1, 0, 32'd8, 32'h0, 4'hF, a2);
    chk("wr_thru", 32'(a2 - a1), 32'd2);
    get_rd("t1", a2, 32'h12345678, 2);
    // Partial byteenable after clearing the register
    issue(0, 1, 32'd12, 32'h0, 4'hF, a1);
    issue(0, 1, 32'd12, 32'hAABBCCDD, 4'b0101, a1);
    issue(1, 0, 32'd12, 32'h0, 4'hF, a2);
    get_rd("t2", a2, 32'h00BB00DD, 2);
    // Stalling slave: 3 cycles of waitrequest, readdatavalid 4 cycles after acceptance
    wait_n = 3; rdv_d = 4;
    m0 = mread_cyc;
    issue(1, 0, 32'd8, 32'h0, 4'hF, a2);
    get_rd("t3", a2, 32'h12345678, 2 + 3 + 4);
    chk("t3_mrd_len", 32'(mread_cyc - m0), 32'd4);
    chk("t3_tmo", 32'(timeouts), 32'd0);
    wait_n = 0; rdv_d = 0;
    // Slave never returns data: abort with ERR_DATA
    never = 1;
    issue(1, 0, 32'd8, 32'h0, 4'hF, a2);
    get_rd("t4", a2, ERR, TO + 1);
    chk("t4_tmo", 32'(timeouts), 32'd1);
    never = 0;
    issue(0, 1, 32'd16, 32'h5A5A1234, 4'hF, a1);
    issue(1, 0, 32'd16, 32'h0, 4'hF, a2);
    get_rd("t4b", a2, 32'h5A5A1234, 2);
    chk("t4b_tmo", 32'(timeouts), 32'd1);
    // Read and write together: write wins, no read response
    p0 = rdv_pulses;
    issue(1, 1, 32'd0, 32'hCAFEF00D, 4'hF, a1);
    repeat (10) @(negedge clk);
    chk("t5_no_rdv", 32'(rdv_pulses - p0), 32'd0);
    issue(1, 0, 32'd0, 32'h0, 4'hF, a2);
    get_rd("t5", a2, 32'hCAFEF00D, 2);
    // Reset while waiting for read data
    never = 1;
    issue(1, 0, 32'd16, 32'h0, 4'hF, a2);
    repeat (4) @(negedge clk);
    chk("t6_in_wait", 32'({m_read, s_waitrequest}), 32'd1);
    #2 rst = 0;
    #1;
    chk("t6_wait", 32'(s_waitrequest), 32'd1);
    chk("t6_mrd", 32'({m_read, m_write}), 32'd0);
    chk("t6_maddr", m_address, 32'd0);
    chk("t6_mbe", 32'(m_byteenable), 32'd0);
    chk("t6_srd", s_readdata, 32'd0);
    chk("t6_srdv", 32'(s_readdatavalid), 32'd0);
    chk("t6_tmo", 32'(timeouts), 32'd0);
    never = 0;
    p0 = rdv_pulses;
    @(negedge clk) rst = 1;
    repeat (20) @(negedge clk);
    chk("t6_no_rdv", 32'(rdv_pulses - p0), 32'd0);
    chk("t6_ready", 32'(s_waitrequest), 32'd0);
    issue(0, 1, 32'd4, 32'h0BADF00D, 4'hF, a1);
    issue(1, 0, 32'd4, 32'h0, 4'hF, a2);
    get_rd("t6", a2, 32'h0BADF00D, 2);
    // Randomized traffic against the memory/latency model
    for (int k = 0; k < 40; k++) begin
      a = 32'($urandom_range(0, 7) * 4);
      d = $urandom;
      be = 4'($urandom_range(0, 15));
      wait_n = $urandom_range(0, 3);
      rdv_d = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) issue(0, 1, a, d, be, a1);
      else begin
        issue(1, 0, a, d, be, a2);
        get_rd("rnd", a2, ref_mem[a[4:2]], 2 + wait_n + rdv_d);
      end
    end
    repeat (10) @(negedge clk);
    chk("end_tmo", 32'(timeouts), 32'd0);
    chk("end_rdv_count", 32'(rdv_pulses), 32'(nreads));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mm_bridge.md
# mm_bridge

Single-outstanding Avalon-MM bridge that sits between the JTAG-to-Avalon master (`vjtag_mm`) and the register bank slave on the DE0-Nano. It registers every master command and replays it to the slave. It returns read data with a fixed minimum latency and enforces a timeout, so a stalled or missing slave never hangs the JTAG debug path. Its slave-side port (`s_*`) connects to the master; its master-side port (`m_*`) connects to the register bank.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles a transaction may spend downstream before abort; legal range 1..255.
- `ERR_DATA`, 32'hDEADBEEF: read data returned on timeout.

Ports:
- `clk`  in  1  system clock (PLL c0).
- `rst`  in  1  reset, asynchronous, active-low; connected to PLL `locked`.
- `s_address`  in  32  byte address from the master.
- `s_read` / `s_write`  in  1  command strobes from the master.
- `s_writedata`  in  32  write data from the master.
- `s_byteenable`  in  4  byte lanes from the master.
- `s_waitrequest`  out  1  stall signal to the master.
- `s_readdata`  out  32  read data to the master.
- `s_readdatavalid`  out  1  one-cycle read-return strobe to the master.
- `m_address` / `m_writedata` / `m_byteenable`  out  32/32/4  registered command to the slave.
- `m_read` / `m_write`  out  1  registered strobes to the slave.
- `m_waitrequest`  in  1  slave stall.
- `m_readdata`  in  32  slave read data.
- `m_readdatavalid`  in  1  slave read-return strobe.
- `timeouts`  out  8  saturating count of aborted transactions.

## Operation
- FSM states are IDLE, CMD, WAIT_RD and RESP. Reset state is IDLE.
- `s_waitrequest` is combinational: it is 1 when `rst` is 0 or when state ≠ IDLE.
- IDLE: when `s_read` or `s_write` is high, the command is accepted in that cycle.
  - The bridge latches address, writedata, byteenable and kind, then goes to CMD.
  - If `s_read` and `s_write` are both high, the command is a write; the read is dropped.
- CMD: drives `m_read` or `m_write` with the latched fields.
  - Completion (slave accepts the command) occurs when `m_waitrequest` is 0.
  - On completion of a write, go to IDLE.
  - On completion of a read with `m_readdatavalid` high in the same cycle, capture `m_readdata` and go to RESP.
  - On completion of a read with `m_readdatavalid` low, go to WAIT_RD.
- WAIT_RD: `m_read` is 0. When `m_readdatavalid` is high, capture `m_readdata` and go to RESP.
- RESP: `s_readdatavalid` is 1 for exactly one cycle with `s_readdata` holding the captured data, then go to IDLE.
- `m_readdatavalid` seen in IDLE, CMD before completion, or RESP is ignored.
- Timeout: an 8-bit counter clears on entry to CMD and increments each cycle in CMD or WAIT_RD.
  - When the count equals `TIMEOUT-1` and no completion occurs in that cycle, the transaction aborts.
  - On abort the strobes drop and `timeouts` increments, saturating at 255.
  - An aborted read goes to RESP with `s_readdata = ERR_DATA`. An aborted write goes to IDLE.
  - If completion and timeout occur in the same cycle, completion wins.
- `s_readdata` holds its last value outside RESP.
- Reset values:
  - state IDLE; `m_read` and `m_write` 0.
  - `m_address`, `m_writedata`, `m_byteenable` 0.
  - `s_readdata` 0, `s_readdatavalid` 0, `timeouts` 0.
  - `s_waitrequest` 1 while `rst` is low.
- Reset asserted mid-transaction: all state clears immediately. No read response is issued for the in-flight read.

## Timing
- Every output except `s_waitrequest` is registered.
- Zero-wait slave (such as the register bank: waitrequest=0, readdatavalid=1, combinational readdata):
  - Read accepted in cycle N; `m_read` is high in N+1; `s_readdatavalid` is high in N+2.
  - Write accepted in cycle N; `m_write` is high in N+1; the next command can be accepted in N+2.
- Each cycle of `m_waitrequest` or `m_readdatavalid` delay adds exactly one cycle of latency.
- Abort occurs `TIMEOUT` cycles after CMD entry. An aborted read returns `s_readdatavalid` in the following cycle.
- Throughput: one transaction per 2 cycles for writes and 3 cycles for reads.

## Test plan
- Write 32'h12345678 to address 8 with byteenable 4'hF against the register bank, then read address 8 → `s_readdatavalid` exactly 2 cycles after read acceptance, `s_readdata` = 32'h12345678.
- Write 32'hAABBCCDD with byteenable 4'b0101 to address 12 after the register is cleared → readback = 32'h00BB00DD.
- Slave model holds `m_waitrequest` for 3 cycles and delays `m_readdatavalid` by 4 cycles:
  - `m_read` stays high exactly 4 cycles;
  - `s_waitrequest` stays high until RESP completes;
  - data returns correctly; `timeouts` = 0.
- `TIMEOUT` = 16, slave never returns readdatavalid:
  - `s_readdatavalid` arrives with 32'hDEADBEEF;
  - `timeouts` = 1;
  - a following write completes normally.
- `s_read` and `s_write` both high at address 0 → a write is performed, no `s_readdatavalid` is ever issued.
- `rst` pulled low while in WAIT_RD → outputs return to reset values asynchronously, no spurious `s_readdatavalid`, the first command after release is accepted.
